keypad_conditioner: RTL and testbench
=====================================

// Module: keypad_conditioner
// PURPOSE
//  Upstream stage of the keypad-driven VGA sprite FSM. Synchronises and debounces raw
//  key lines, picks one active key, and emits one-cycle one-hot move strobes on keypad[7:0].
//  Emits one strobe on press, then optional auto-repeat strobes while the key is held.
//  Consumer samples keypad[] only in its idle/poll state.
// PARAMETERS
//  NKEYS           8           number of key lines (fixed 8 for the sprite FSM)
//  DEBOUNCE_CYCLES 250000      consecutive disagreeing samples needed to flip a debounced level
//  REPEAT_DELAY    25000000    cycles from the first strobe to the first repeat strobe
//  REPEAT_PERIOD   5000000     cycles between subsequent repeat strobes
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  key_raw    in   NKEYS  raw key lines, asynchronous, active-high
//  keypad     out  NKEYS  one-hot move strobe, high for exactly 1 cycle per event
//  key_level  out  NKEYS  debounced key levels
//  key_active out  1      high while a key is owned by the repeat FSM (HOLD/REPEAT)
// BEHAVIOUR
//  Reset: keypad=0, key_level=0, key_active=0, synchronisers=0, counters=0, FSM=IDLE.
//  A key held through reset is treated as a fresh press after debounce.
//  Sync: 2-flop synchroniser per key.
//  Debounce, per key: cnt++ while sync!=level; cnt cleared when sync==level.
//   level flips on the edge where the mismatch has lasted DEBOUNCE_CYCLES consecutive cycles.
//   That edge also clears cnt. Any single agreeing sample restarts the count.
//   cnt width = $clog2(DEBOUNCE_CYCLES+1) and never overflows.
//  Latency: raw edge -> key_level change = 2 + DEBOUNCE_CYCLES cycles.
//   key_level rise -> keypad strobe = 1 cycle.
//  Priority: lowest-index debounced key wins. act_idx is registered on IDLE->HOLD.
//  FSM states:
//   IDLE: if any key_level: latch act_idx, strobe keypad[act_idx], load tmr=REPEAT_DELAY-1, ->HOLD.
//   HOLD: if !key_level[act_idx] ->IDLE. Else if tmr==0: strobe, tmr=REPEAT_PERIOD-1, ->REPEAT. Else tmr--.
//   REPEAT: if !key_level[act_idx] ->IDLE. Else if tmr==0: strobe, reload REPEAT_PERIOD-1. Else tmr--.
//  Other keys pressed while a key is active: ignored, no strobe.
//   If they are still held when the active key releases, IDLE picks the lowest one
//   on the next cycle and strobes it (release->new strobe = 1 cycle gap min).
//  Release and timer expiry in the same cycle: release wins, no strobe.
//  keypad is always one-hot or zero; never two bits set.
//  tmr is 32-bit unsigned. REPEAT_DELAY and REPEAT_PERIOD must be >=1.
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined: HOLD/REPEAT timing as above.
//  Not defined: no repeat timers. HOLD waits for release only, giving exactly one strobe per press.
//   The REPEAT state and tmr are not synthesised; key_active still high during HOLD.
// STRUCTURE
//  keypad_pkg:
//   state enum {IDLE, HOLD, REPEAT}.
//   key index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_DOWN=2, KEY_UP=3.
//  Sub-module key_debounce (sync + counter + level), one instance per key via generate.
//  Top module: priority encoder, repeat FSM, strobe register.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  Reset: assert rst 3 cycles with key_raw=8'h0F -> all outputs 0.
//   After release, key_level=8'h0F at cycle 6, keypad=8'h01 at cycle 7.
//  Bounce: key_raw[2] toggles every 2 cycles for 20 cycles, then held 1.
//   key_level[2] stays 0 during toggling, rises 6 cycles after the hold starts.
//   Exactly one keypad=8'h04 strobe follows.
//  Repeat (EN defined): hold key 1 for 30 cycles after its first strobe.
//   Strobes at +0, +10, +13, +16, ... ; no strobe after key_level[1] falls.
//  No repeat (EN undefined): same stimulus -> exactly one keypad=8'h02 strobe.
//  Priority: press keys 3 and 0 together -> strobe 8'h01 only.
//   Release key 0 with key 3 held -> IDLE, then strobe 8'h08 next cycle.
//  Collision: release key 0 on the cycle its repeat tmr hits 0 -> no strobe; FSM returns to IDLE.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad conditioner: FSM states, key indices,
// and the lowest-index priority pick used when choosing the active key.
package keypad_pkg;

    localparam int NKEYS = 8;
    localparam int IDX_W = $clog2(NKEYS);

    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_UP    = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    function automatic logic [IDX_W-1:0] lowest_key(input logic [NKEYS-1:0] lv);
        lowest_key = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (lv[i]) lowest_key = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_conditioner_if.sv
// Key input/strobe bundle between the keypad conditioner and the sprite FSM.
interface keypad_conditioner_if;
    import keypad_pkg::*;

    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] keypad;
    logic [NKEYS-1:0] key_level;
    logic             key_active;

    modport master (
        input  key_raw,
        output keypad,
        output key_level,
        output key_active
    );

    modport slave (
        output key_raw,
        input  keypad,
        input  key_level,
        input  key_active
    );

endinterface

// File: rtl/keypad_conditioner_key_debounce.sv
// One key line: 2-flop synchroniser followed by a consecutive-mismatch debounce counter.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                // Flip on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad conditioner top: per-key debounce, lowest-index priority, repeat FSM, strobe register.
// Auto-repeat is built only when KEYPAD_AUTOREPEAT_EN is defined.
//
//   state  | meaning
//   IDLE   | no key owned; first debounced key gets latched and strobed
//   HOLD   | key owned; waiting for release (or REPEAT_DELAY expiry when repeat is built)
//   REPEAT | key owned; strobing every REPEAT_PERIOD cycles until release
module keypad_conditioner
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input logic                  clk,
    input logic                  rst,
    keypad_conditioner_if.master bus
);

    logic [NKEYS-1:0] level;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] act_q, act_d;
    logic [NKEYS-1:0] keypad_q, keypad_d;

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.key_raw[g]),
            .level(level[g])
        );
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [31:0] tmr_q, tmr_d;

    always_ff @(posedge clk) begin
        if (rst) tmr_q <= '0;
        else     tmr_q <= tmr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            act_q    <= '0;
            keypad_q <= '0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            keypad_q <= keypad_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        keypad_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        tmr_d    = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|level) begin
                    act_d    = lowest_key(level);
                    keypad_d = NKEYS'(1) << act_d;
                    state_d  = HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    tmr_d    = 32'(REPEAT_DELAY - 1);
`endif
                end
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            // Release is tested first so it beats a same-cycle timer expiry.
            HOLD, REPEAT: begin
                if (!level[act_q]) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    keypad_d = NKEYS'(1) << act_q;
                    tmr_d    = 32'(REPEAT_PERIOD - 1);
                    state_d  = REPEAT;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
`else
            HOLD: begin
                if (!level[act_q]) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.keypad     = keypad_q;
    assign bus.key_level  = level;
    assign bus.key_active = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3); follows KEYPAD_AUTOREPEAT_EN.
module tb_keypad_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    exp_t e;

    keypad_conditioner_if bus();

    keypad_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every nonzero keypad sample must match the next queued strobe in value and cycle.
    always @(negedge clk) begin
        if (!rst && bus.keypad !== 8'h00) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected: cycle=%0d keypad=%02h required=none", cyc, bus.keypad);
            end else begin
                e = exp_q.pop_front();
                if (bus.keypad !== e.val || cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL strobe: cycle=%0d keypad=%02h required cycle=%0d keypad=%02h",
                             cyc, bus.keypad, e.cyc, e.val);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [7:0] v);
        exp_t x;
        x.cyc = c;
        x.val = v;
        exp_q.push_back(x);
    endtask

    task automatic test_reset;
        int n;
        bus.key_raw = 8'h0F;
        rst = 1'b1;
        tick(3);
        checks++;
        if (bus.keypad !== 8'h00) begin
            failures++; $display("FAIL reset_keypad: got=%02h required=00", bus.keypad);
        end
        checks++;
        if (bus.key_level !== 8'h00) begin
            failures++; $display("FAIL reset_level: got=%02h required=00", bus.key_level);
        end
        checks++;
        if (bus.key_active !== 1'b0) begin
            failures++; $display("FAIL reset_active: got=%b required=0", bus.key_active);
        end
        rst = 1'b0;
        n = cyc;
        push_exp(n + 7, 8'h01);
        tick(5);
        checks++;
        if (bus.key_level !== 8'h00) begin
            failures++; $display("FAIL reset_level_early: got=%02h required=00", bus.key_level);
        end
        tick(1);
        checks++;
        if (bus.key_level !== 8'h0F) begin
            failures++; $display("FAIL reset_level_rise: got=%02h required=0F", bus.key_level);
        end
        tick(1);
        bus.key_raw = 8'h00;
        tick(20);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL reset_drain: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce;
        int  h;
        logic seen_high;
        seen_high = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.key_raw[2] = ~bus.key_raw[2];
            tick(1);
            if (bus.key_level[2]) seen_high = 1'b1;
            tick(1);
            if (bus.key_level[2]) seen_high = 1'b1;
        end
        checks++;
        if (seen_high !== 1'b0) begin
            failures++; $display("FAIL bounce_level_toggling: got=1 required=0");
        end
        bus.key_raw[2] = 1'b1;
        h = cyc;
        push_exp(h + 7, 8'h04);
        tick(5);
        checks++;
        if (bus.key_level[2] !== 1'b0) begin
            failures++; $display("FAIL bounce_level_early: got=%b required=0", bus.key_level[2]);
        end
        tick(1);
        checks++;
        if (bus.key_level[2] !== 1'b1) begin
            failures++; $display("FAIL bounce_level_rise: got=%b required=1", bus.key_level[2]);
        end
        tick(1);
        bus.key_raw[2] = 1'b0;
        tick(20);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL bounce_drain: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_repeat;
        int s;
        bus.key_raw[1] = 1'b1;
        s = cyc + 7;
        push_exp(s, 8'h02);
`ifdef KEYPAD_AUTOREPEAT_EN
        // Level falls at s+36, so the last repeat lands at s+34.
        for (int k = 0; k < 9; k++) push_exp(s + RD + RP * k, 8'h02);
`endif
        tick(7);
        checks++;
        if (bus.key_active !== 1'b1) begin
            failures++; $display("FAIL repeat_active: got=%b required=1", bus.key_active);
        end
        tick(30);
        bus.key_raw[1] = 1'b0;
        tick(20);
        checks++;
        if (bus.key_active !== 1'b0) begin
            failures++; $display("FAIL repeat_idle: got=%b required=0", bus.key_active);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL repeat_drain: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_priority;
        int n;
        bus.key_raw = 8'h09;
        n = cyc;
        push_exp(n + 7, 8'h01);
        push_exp(n + 15, 8'h08);
        tick(7);
        bus.key_raw[0] = 1'b0;
        tick(6);
        checks++;
        if (bus.key_active !== 1'b1) begin
            failures++; $display("FAIL priority_held: got=%b required=1", bus.key_active);
        end
        tick(1);
        checks++;
        if (bus.key_active !== 1'b0) begin
            failures++; $display("FAIL priority_idle_gap: got=%b required=0", bus.key_active);
        end
        tick(1);
        bus.key_raw[3] = 1'b0;
        tick(20);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL priority_drain: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_collision;
        int s;
        bus.key_raw[0] = 1'b1;
        s = cyc + 7;
        push_exp(s, 8'h01);
        tick(10);
        // Level falls at s+9, the cycle the HOLD timer reads zero.
        bus.key_raw[0] = 1'b0;
        tick(6);
        checks++;
        if (bus.key_level[0] !== 1'b0 || bus.key_active !== 1'b1) begin
            failures++;
            $display("FAIL collision_pre: level=%b active=%b required level=0 active=1",
                     bus.key_level[0], bus.key_active);
        end
        tick(1);
        checks++;
        if (bus.key_active !== 1'b0) begin
            failures++; $display("FAIL collision_idle: got=%b required=0", bus.key_active);
        end
        tick(10);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL collision_drain: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.key_raw = 8'h00;
        test_reset();
        test_bounce();
        test_repeat();
        test_priority();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
